puls_sync_arb: RTL

Source-domain arbiter that shares one pulse handshake synchronizer channel among NUM_REQ requesters. Each requester posts single-cycle events. The block latches them as pending, picks one round-robin whenever the synchronizer reports ready, and launches a one-cycle pulse together with a requester ID. The ID is held stable for the full handshake so the destination side can sample it as a quasi-static bus on the synchronized pulse.

---
 rtl/puls_sync_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/puls_sync_arb.sv
// Round-robin arbiter sharing one pulse handshake synchronizer among NUM_REQ sources.
// Optional handshake timeout enabled by defining PSA_TIMEOUT_EN.
module puls_sync_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TO_CYC  = 255,
  parameter int TO_W    = 8
) (
  input  logic               i_clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req_puls,
  output logic [NUM_REQ-1:0] o_req_busy,
  input  logic               i_sync_ready,
  output logic               o_sync_puls,
  output logic [ID_W-1:0]    o_sync_id,
  output logic [NUM_REQ-1:0] o_done,
  output logic [NUM_REQ-1:0] o_ovf,
  output logic               o_to_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOW,
    WAIT_HIGH
  } state_t;

  if ((1 << ID_W) < NUM_REQ) begin : g_bad_id_w
    $error("ID_W too narrow for NUM_REQ");
  end
  if ((1 << TO_W) <= TO_CYC) begin : g_bad_to_w
    $error("TO_W too narrow for TO_CYC");
  end

  state_t             r_state;
  state_t             w_state_n;
  logic [NUM_REQ-1:0] r_pend;
  logic [NUM_REQ-1:0] w_pend_n;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] w_done_n;
  logic [NUM_REQ-1:0] r_ovf;
  logic [NUM_REQ-1:0] w_ovf_n;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    w_ptr_n;
  logic [ID_W-1:0]    r_sync_id;
  logic [ID_W-1:0]    w_id_n;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               r_sync_puls;
  logic               w_puls_n;

  // First pending bit at or after ptr+1, wrapping modulo NUM_REQ
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_ptr) + 1 + k) % NUM_REQ);
      if (!w_any && r_pend[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

`ifdef PSA_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_cnt_n;
  logic            r_to_err;
  logic            w_to_n;
`endif

  always_comb begin
    w_state_n = r_state;
    w_pend_n  = r_pend;
    w_done_n  = '0;
    w_ovf_n   = '0;
    w_puls_n  = 1'b0;
    w_id_n    = r_sync_id;
    w_ptr_n   = r_ptr;
`ifdef PSA_TIMEOUT_EN
    w_cnt_n   = '0;
    w_to_n    = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_any && i_sync_ready) begin
          w_puls_n        = 1'b1;
          w_id_n          = w_win;
          w_ptr_n         = w_win;
          w_pend_n[w_win] = 1'b0;
          w_state_n       = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!i_sync_ready) w_state_n = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (i_sync_ready) begin
          w_done_n[r_sync_id] = 1'b1;
          w_state_n           = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
`ifdef PSA_TIMEOUT_EN
    if (r_state != IDLE) begin
      if (r_to_cnt == TO_W'(TO_CYC)) begin
        w_to_n    = 1'b1;
        w_done_n  = '0;
        w_state_n = IDLE;
      end else if (w_state_n == r_state) begin
        w_cnt_n = r_to_cnt + 1'b1;
      end
    end
`endif
    // A grant-cycle request re-queues cleanly: winner bit is already cleared
    w_ovf_n  = i_req_puls & w_pend_n;
    w_pend_n = w_pend_n | i_req_puls;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_done      <= '0;
      r_ovf       <= '0;
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_sync_id   <= '0;
      r_sync_puls <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_pend      <= w_pend_n;
      r_done      <= w_done_n;
      r_ovf       <= w_ovf_n;
      r_ptr       <= w_ptr_n;
      r_sync_id   <= w_id_n;
      r_sync_puls <= w_puls_n;
    end
  end

`ifdef PSA_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_cnt <= w_cnt_n;
      r_to_err <= w_to_n;
    end
  end
  assign o_to_err = r_to_err;
`else
  assign o_to_err = 1'b0;
`endif

  assign o_req_busy  = r_pend;
  assign o_sync_puls = r_sync_puls;
  assign o_sync_id   = r_sync_id;
  assign o_done      = r_done;
  assign o_ovf       = r_ovf;

endmodule
